sram_b_reader: RTL and testbench

Read sequencer on the consumer side of the SRAM_B weight/feature buffer (56 words x 129 bits, one-cycle registered read). On a start command it walks a range of SRAM_B addresses, absorbs the one-cycle read latency, and streams words to the downstream convolution datapath over a valid/ready interface. Full rate is one word per cycle. Downstream backpressure never drops or duplicates a word.

---
 rtl/sram_b_reader_pkg.sv | 28 ++
 rtl/sram_b_rd_fifo.sv | 89 ++++++++
 rtl/sram_b_reader.sv | 148 ++++++++++++++
 tb/tb_sram_b_reader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_b_reader_pkg.sv
// Shared constants, FSM encoding and address helper for the SRAM_B read sequencer.
package sram_b_reader_pkg;

    localparam int SRAM_B_DEPTH  = 56;
    localparam int SRAM_B_DATA_W = 129;
    localparam int SRAM_B_ADDR_W = 6;

    localparam logic [SRAM_B_ADDR_W-1:0] SRAM_B_LAST_ADDR = 6'd55;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t ST_IDLE  = 2'd0;
    localparam rd_state_t ST_RUN   = 2'd1;
    localparam rd_state_t ST_DRAIN = 2'd2;
    localparam rd_state_t ST_DONE  = 2'd3;

    // Address increment that wraps at the physical depth, not at 2^ADDR_W.
    function automatic logic [SRAM_B_ADDR_W-1:0] sram_b_addr_inc(input logic [SRAM_B_ADDR_W-1:0] addr);
        logic [SRAM_B_ADDR_W-1:0] nxt;
        if (addr == SRAM_B_LAST_ADDR) begin
            nxt = 6'd0;
        end else begin
            nxt = addr + 6'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sram_b_rd_fifo.sv
// Two-entry head/tail FIFO; the head register feeds the stream output directly.
module sram_b_rd_fifo #(
    parameter int W = 130
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         head_valid,
    output logic [1:0]   count
);

    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic [1:0]   count_r;
    logic         valid_r;

    logic [W-1:0] head_next_s;
    logic [W-1:0] tail_next_s;
    logic [1:0]   count_next_s;

    // Next-state computation for push, pop and simultaneous push+pop.
    always_comb begin
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        count_next_s = count_r;
        case ({push, pop})
            2'b10: begin
                if (count_r == 2'd0) begin
                    head_next_s  = push_data;
                    count_next_s = 2'd1;
                end else if (count_r == 2'd1) begin
                    tail_next_s  = push_data;
                    count_next_s = 2'd2;
                end else begin
                    count_next_s = count_r;
                end
            end
            2'b01: begin
                if (count_r == 2'd0) begin
                    count_next_s = 2'd0;
                end else begin
                    head_next_s  = tail_r;
                    count_next_s = count_r - 2'd1;
                end
            end
            2'b11: begin
                if (count_r == 2'd2) begin
                    head_next_s = tail_r;
                    tail_next_s = push_data;
                end else begin
                    head_next_s  = push_data;
                    count_next_s = 2'd1;
                end
            end
            default: begin
                count_next_s = count_r;
            end
        endcase
        // Empty FIFO presents an all-zero head so stale words never linger on the bus.
        if (count_next_s == 2'd0) begin
            head_next_s = '0;
        end else begin
            head_next_s = head_next_s;
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
            valid_r <= (count_next_s != 2'd0);
        end
    end

    assign head       = head_r;
    assign head_valid = valid_r;
    assign count      = count_r;

endmodule

// File: rtl/sram_b_reader.sv
// SRAM_B read sequencer: walks an address range, hides the one-cycle read latency,
// and streams words downstream over valid/ready without loss or duplication.
module sram_b_reader
    import sram_b_reader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SRAM_B_ADDR_W-1:0] base_addr,
    input  logic [SRAM_B_ADDR_W-1:0] len,
    output logic                     busy,
    output logic                     done,
    output logic [SRAM_B_ADDR_W-1:0] sram_addr,
    input  logic [SRAM_B_DATA_W-1:0] sram_dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SRAM_B_DATA_W-1:0] out_data,
    output logic                     out_last
);

    rd_state_t state_r;
    rd_state_t state_next_s;

    logic [SRAM_B_ADDR_W-1:0] rd_addr_r;
    logic [SRAM_B_ADDR_W-1:0] hold_addr_r;
    logic [SRAM_B_ADDR_W-1:0] len_r;
    logic [SRAM_B_ADDR_W-1:0] issued_r;
    logic                     inflight_r;
    logic                     inflight_last_r;
    logic                     busy_r;
    logic                     done_r;

    logic                     pop_s;
    logic                     issue_s;
    logic                     last_issue_s;
    logic                     cmd_load_s;
    logic [2:0]               occupancy_s;
    logic [1:0]               fifo_count_s;
    logic                     fifo_valid_s;
    logic [SRAM_B_DATA_W:0]   fifo_head_s;

    // Credit check: words buffered plus in flight, after this cycle's pop, must stay below two.
    always_comb begin
        pop_s        = fifo_valid_s & out_ready;
        occupancy_s  = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        last_issue_s = (issued_r == (len_r - 6'd1));
        cmd_load_s   = (state_r == ST_IDLE) && start && (len != 6'd0);
        if ((state_r == ST_RUN) && (issued_r < len_r) && (occupancy_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        if (issue_s) begin
            sram_addr = rd_addr_r;
        end else begin
            sram_addr = hold_addr_r;
        end
    end

    // Command FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && (len != 6'd0)) begin
                    state_next_s = ST_RUN;
                end else if (start) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s && last_issue_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && fifo_head_s[SRAM_B_DATA_W]) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, address walk, issue bookkeeping and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            rd_addr_r       <= 6'd0;
            hold_addr_r     <= 6'd0;
            len_r           <= 6'd0;
            issued_r        <= 6'd0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            busy_r          <= (state_next_s != ST_IDLE);
            done_r          <= (state_next_s == ST_DONE);
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s && last_issue_s;
            if (cmd_load_s) begin
                rd_addr_r <= base_addr;
                len_r     <= len;
                issued_r  <= 6'd0;
            end else if (issue_s) begin
                rd_addr_r   <= sram_b_addr_inc(rd_addr_r);
                issued_r    <= issued_r + 6'd1;
                hold_addr_r <= rd_addr_r;
            end else begin
                rd_addr_r <= rd_addr_r;
            end
        end
    end

    // The last-word marker travels alongside the data through the buffer.
    sram_b_rd_fifo #(
        .W (SRAM_B_DATA_W + 1)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_r),
        .push_data  ({inflight_last_r, sram_dout}),
        .pop        (pop_s),
        .head       (fifo_head_s),
        .head_valid (fifo_valid_s),
        .count      (fifo_count_s)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign out_valid = fifo_valid_s;
    assign out_data  = fifo_head_s[SRAM_B_DATA_W-1:0];
    assign out_last  = fifo_head_s[SRAM_B_DATA_W];

endmodule

// File: tb/tb_sram_b_reader.sv
// Directed bench for sram_b_reader with a registered-read SRAM_B model.
module tb_sram_b_reader;
    import sram_b_reader_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [5:0]   base_addr;
    logic [5:0]   len;
    logic         busy;
    logic         done;
    logic [5:0]   sram_addr;
    logic [128:0] sram_dout;
    logic         out_valid;
    logic         out_ready;
    logic [128:0] out_data;
    logic         out_last;

    logic [128:0] mem [0:55];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_b_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always @(posedge clk) sram_dout <= mem[sram_addr];

    function automatic logic [128:0] word_of(input int i);
        logic [128:0] w;
        w = 129'(i);
        w[128:120] = 9'(i);
        w[64] = ~w[0];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input int b, input int l, input int mode, input int abort_after, input bit inject);
        int cyc;
        int idx;
        int first_v;
        int last_hs;
        bit fin;
        bit prev_stall;
        logic [128:0] prev_data;
        logic prev_last;
        @(negedge clk);
        start = 1'b1;
        base_addr = 6'(b);
        len = 6'(l);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        idx = 0;
        first_v = -1;
        last_hs = -1;
        fin = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        while (!fin) begin
            if (inject && cyc == 4) begin
                start = 1'b1;
                base_addr = 6'd5;
                len = 6'd3;
            end else begin
                start = 1'b0;
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (prev_stall) begin
                chk("stall_valid", 160'(out_valid), 160'(1));
                chk("stall_data", 160'(out_data), 160'(prev_data));
                chk("stall_last", 160'(out_last), 160'(prev_last));
            end
            if (mode == 1)
                chk("occupancy_le2", 160'((dut.u_fifo.count_r + dut.inflight_r) <= 2), 160'(1));
            if (mode == 0 && cyc <= l)
                chk("sram_addr", 160'(sram_addr), 160'((b + cyc - 1) % 56));
            if (done) begin
                chk("done_after_last", 160'(cyc), 160'(last_hs + 1));
                chk("busy_with_done", 160'(busy), 160'(1));
                fin = 1'b1;
            end
            if (mode == 1) begin
                if (cyc >= 3 && cyc <= 8) out_ready = (cyc % 2 == 1);
                else if (cyc >= 9 && cyc <= 13) out_ready = 1'b0;
                else out_ready = 1'b1;
            end else begin
                out_ready = 1'b1;
            end
            if (!fin && out_valid && out_ready) begin
                chk("out_data", 160'(out_data), 160'(word_of((b + idx) % 56)));
                chk("out_last", 160'(out_last), 160'(idx == l - 1));
                idx++;
                last_hs = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (abort_after > 0 && idx == abort_after) fin = 1'b1;
            if (cyc > 400) begin
                chk("timeout", 160'(0), 160'(1));
                fin = 1'b1;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (abort_after == 0) begin
            chk("word_count", 160'(idx), 160'(l));
            if (mode == 0) begin
                chk("first_valid_cycle", 160'(first_v), 160'(3));
                chk("last_hs_cycle", 160'(last_hs), 160'(l + 2));
            end
            @(negedge clk);
            chk("done_one_cycle", 160'(done), 160'(0));
            chk("busy_dropped", 160'(busy), 160'(0));
            chk("idle_no_valid", 160'(out_valid), 160'(0));
        end
    endtask

    initial begin
        int vcount;
        logic [5:0] addr_before;
        rst = 1'b1;
        start = 1'b0;
        base_addr = 6'd0;
        len = 6'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 56; i++) mem[i] = word_of(i);

        repeat (3) @(negedge clk);
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_done", 160'(done), 160'(0));
        chk("rst_sram_addr", 160'(sram_addr), 160'(0));
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        chk("rst_out_data", 160'(out_data), 160'(0));
        chk("rst_out_last", 160'(out_last), 160'(0));
        chk("rst_state", 160'(dut.state_r), 160'(ST_IDLE));
        rst = 1'b0;
        out_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("idle_quiet", 160'(vcount), 160'(0));

        run_cmd(0, 56, 0, 0, 1'b0);
        run_cmd(50, 10, 0, 0, 1'b0);
        run_cmd(0, 16, 1, 0, 1'b0);

        @(negedge clk);
        addr_before = sram_addr;
        start = 1'b1;
        base_addr = 6'd7;
        len = 6'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", 160'(done), 160'(1));
        chk("len0_valid", 160'(out_valid), 160'(0));
        chk("len0_addr", 160'(sram_addr), 160'(addr_before));
        @(negedge clk);
        chk("len0_done_drop", 160'(done), 160'(0));
        chk("len0_busy_drop", 160'(busy), 160'(0));

        run_cmd(0, 8, 0, 0, 1'b1);
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid || busy) vcount++;
        end
        chk("ignored_start_quiet", 160'(vcount), 160'(0));

        run_cmd(0, 56, 0, 20, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 160'(out_valid), 160'(0));
        chk("midrst_busy", 160'(busy), 160'(0));
        chk("midrst_done", 160'(done), 160'(0));
        rst = 1'b0;
        run_cmd(10, 4, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
